// File: rtl/id_ex_stage.sv
// id_ex_stage
// Pipeline register between instruction decode and the 16-bit ALU.
// Holds one decoded instruction and forwards MEM/WB results into its
// operands. It also detects load-use hazards, which insert one bubble.
// Both downstream backpressure (ex_ready) and branch flush are supported.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   in_valid / in_ready           decode handshake
//   in_rs1, in_rs2, in_rd         source/destination register numbers
//   in_rs1_data, in_rs2_data      register-file read data
//   in_imm, in_use_imm            immediate and b-operand select
//   in_alu_control                ALU function
//   in_reg_write/mem_read/mem_write  instruction class flags
//   flush                         drop held and incoming instruction
//   ex_ready                      execute consumes out_valid this cycle
//   mem_fwd_*, wb_fwd_*           forwarding sources (MEM has priority)
//   out_valid                     held instruction valid
//   alu_a, alu_b                  forwarded ALU operands
//   out_alu_control, out_rd       held ALU function / destination
//   out_reg_write/mem_read/mem_write  held flags, zero when not valid
//   out_store_data                forwarded rs2 value for stores
//   load_use_stall                load-use hazard active this cycle
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_rs1_data,
  input  logic [DATA_W-1:0] in_rs2_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [CTRL_W-1:0] in_alu_control,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic              mem_fwd_en,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              wb_fwd_en,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [DATA_W-1:0] wb_fwd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] out_alu_control,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [DATA_W-1:0] out_store_data,
  output logic              load_use_stall
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic [CTRL_W-1:0] alu_control;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } held_t;

  state_e state_q, state_d;
  held_t  held_q, held_d;

  logic [DATA_W-1:0] fwd_rs1, fwd_rs2;

  // MEM is younger than WB, so it wins; r0 is hard-wired zero and never forwarded.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [DATA_W-1:0] own,
    input logic              m_en,
    input logic [REG_AW-1:0] m_rd,
    input logic [DATA_W-1:0] m_data,
    input logic              w_en,
    input logic [REG_AW-1:0] w_rd,
    input logic [DATA_W-1:0] w_data
  );
    if (rs != '0 && m_en && m_rd == rs)      return m_data;
    else if (rs != '0 && w_en && w_rd == rs) return w_data;
    else                                     return own;
  endfunction

  assign fwd_rs1 = fwd_sel(held_q.rs1, held_q.rs1_data, mem_fwd_en, mem_fwd_rd,
                           mem_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data);
  assign fwd_rs2 = fwd_sel(held_q.rs2, held_q.rs2_data, mem_fwd_en, mem_fwd_rd,
                           mem_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data);

  assign out_valid       = (state_q == FULL);
  assign alu_a           = fwd_rs1;
  assign alu_b           = held_q.use_imm ? held_q.imm : fwd_rs2;
  assign out_store_data  = fwd_rs2;
  assign out_alu_control = held_q.alu_control;
  assign out_rd          = held_q.rd;
  assign out_reg_write   = out_valid & held_q.reg_write;
  assign out_mem_read    = out_valid & held_q.mem_read;
  assign out_mem_write   = out_valid & held_q.mem_write;

  // A held load's result is not available until WB, so any consumer of it
  // must wait one cycle. Stores always read rs2, even with an immediate b.
  assign load_use_stall = in_valid & out_mem_read & (held_q.rd != '0) &
                          ((held_q.rd == in_rs1) |
                           ((held_q.rd == in_rs2) & (~in_use_imm | in_mem_write)));

  assign in_ready = (~out_valid | ex_ready) & ~load_use_stall & ~flush;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (out_valid && !ex_ready) begin
      // Latch forwarded operands while stalled so they survive the producer
      // leaving the MEM/WB stages.
      held_d.rs1_data = fwd_rs1;
      held_d.rs2_data = fwd_rs2;
    end else if (in_valid && in_ready) begin
      state_d              = FULL;
      held_d.rs1           = in_rs1;
      held_d.rs2           = in_rs2;
      held_d.rd            = in_rd;
      held_d.rs1_data      = in_rs1_data;
      held_d.rs2_data      = in_rs2_data;
      held_d.imm           = in_imm;
      held_d.use_imm       = in_use_imm;
      held_d.alu_control   = in_alu_control;
      held_d.reg_write     = in_reg_write;
      held_d.mem_read      = in_mem_read;
      held_d.mem_write     = in_mem_write;
    end else begin
      state_d = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register and operand-forwarding stage between instruction decode and the 16-bit ALU. Captures decoded operands and control from decode, resolves RAW hazards by forwarding from the MEM and WB stages, detects load-use hazards and inserts bubbles, and presents final `a`/`b` operands plus the 3-bit `alu_control` to the ALU. Supports downstream backpressure and branch flush.

## Interface
- DATA_W, 16, datapath width
- REG_AW, 3, register address width (8 registers; r0 reads as zero)
- CTRL_W, 3, ALU function-select width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_rs1, in_rs2, in_rd  in  REG_AW  source and destination register numbers
- in_rs1_data, in_rs2_data  in  DATA_W  register-file read data
- in_imm  in  DATA_W  sign-extended immediate
- in_use_imm  in  1  ALU b operand is the immediate
- in_alu_control  in  CTRL_W  ALU function
- in_reg_write, in_mem_read, in_mem_write  in  1  instruction class flags
- flush  in  1  discard held and incoming instruction
- ex_ready  in  1  execute stage consumes `out_valid` this cycle
- mem_fwd_en, wb_fwd_en  in  1  MEM/WB stage writes a register with valid data
- mem_fwd_rd, wb_fwd_rd  in  REG_AW  MEM/WB destination register
- mem_fwd_data, wb_fwd_data  in  DATA_W  MEM/WB result
- out_valid  out  1  held instruction valid
- alu_a, alu_b  out  DATA_W  forwarded ALU operands
- out_alu_control  out  CTRL_W  held ALU function
- out_rd  out  REG_AW; out_reg_write, out_mem_read, out_mem_write  out  1 (gated by out_valid)
- out_store_data  out  DATA_W  forwarded rs2 value for stores
- load_use_stall  out  1  load-use hazard active

## Operation
- Two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- Forwarding (combinational, per source rs): if rs≠0, mem_fwd_en, and mem_fwd_rd==rs, use mem_fwd_data. Else if rs≠0, wb_fwd_en, and wb_fwd_rd==rs, use wb_fwd_data. Else use the held register data. MEM has priority over WB. r0 is never forwarded.
- alu_a = fwd(rs1). alu_b = use_imm ? imm : fwd(rs2). out_store_data = fwd(rs2).
- load_use_stall = in_valid & out_valid & out_mem_read & out_rd≠0 & (out_rd==in_rs1 | (out_rd==in_rs2 & ~in_use_imm) | (out_rd==in_rs2 & in_mem_write)).
- in_ready = (~out_valid | ex_ready) & ~load_use_stall & ~flush.
- Clock-edge priority:
  1. flush: out_valid←0.
  2. out_valid & ~ex_ready (hold): all fields kept; held rs1/rs2 data ← their forwarded values, so they stay correct after producers retire.
  3. in_valid & in_ready: capture all in_* fields; out_valid←1.
  4. Otherwise (consumed or bubble): out_valid←0. A load-use hazard with ex_ready therefore inserts exactly one bubble.
- Flags out_reg_write, out_mem_read, out_mem_write are 0 whenever out_valid=0.

## Timing
- Reset: out_valid, all held registers, alu_a, alu_b, out_alu_control, out_rd, all flags, out_store_data, load_use_stall = 0. in_ready = 1 after reset.
- Latency: 1 cycle from accept to out_valid. Forwarding adds no cycles and is combinational from the mem_/wb_ inputs to alu_a/alu_b.
- Back-to-back accept at full throughput while ex_ready=1 and there is no hazard.
- Load followed by a dependent instruction: 1 bubble, then the dependent instruction is accepted. On its EX cycle the load result arrives via wb_fwd.
- flush and in_valid in the same cycle: the incoming instruction is dropped (in_ready=0).
- An asynchronous reset mid-hold returns the stage to EMPTY immediately.

## Test plan
- Reset during FULL: assert rst -> out_valid=0, alu_a=alu_b=0, in_ready=1 at the same instant.
- Accept ADD r3=r1+r2 (rs1_data=5, rs2_data=7, ctrl=000) with ex_ready=1 -> next cycle out_valid=1, alu_a=5, alu_b=7, out_alu_control=000.
- Held rs1=r2 with mem_fwd(r2, 0x1111) and wb_fwd(r2, 0x2222) both enabled -> alu_a=0x1111. With rs1=r0 and both forwards targeting r0 -> alu_a = held data (0).
- LOAD r4, then SUB r5=r4-r1 -> load_use_stall=1 for 1 cycle, one bubble (out_valid=0), SUB accepted next; with wb_fwd(r4, 0x00FF) -> alu_a=0x00FF.
- ex_ready=0 for 3 cycles with rs2=r6 and wb_fwd(r6, 0xABCD) pulsed on cycle 1 only -> alu_b stays 0xABCD through cycle 3; in_ready=0 throughout.
- flush while FULL with in_valid=1 -> next cycle out_valid=0, out_reg_write=0, and the incoming instruction is not captured.
